// File: rtl/id_ex_stage.sv
// ID-stage main control decode, load-use hazard detection and the ID/EX pipeline register.
// A flush or load-use hazard loads a zero bubble into EX and bumps a saturating bubble counter.
module id_ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       id_instr,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic              flush,
  output logic              stall,
  output logic              ex_reg_dst,
  output logic              ex_alu_src,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic [1:0]        ex_alu_op,
  output logic [5:0]        ex_funct,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [15:0]       bubble_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;

  function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{(DATA_W-16){v[15]}}, v};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage p0: combinational decode of the instruction in ID
  logic [5:0]        opcode_p0;
  logic [4:0]        rs_p0, rt_p0;
  logic              reg_dst_p0, alu_src_p0, mem_to_reg_p0, reg_write_p0;
  logic              mem_read_p0, mem_write_p0, branch_p0;
  logic [1:0]        alu_op_p0;
  logic signed [DATA_W-1:0] imm_p0;
  logic              hazard_p0, bubble_p0;

  assign opcode_p0 = id_instr[31:26];
  assign rs_p0     = id_instr[25:21];
  assign rt_p0     = id_instr[20:16];
  assign imm_p0    = sext16(id_instr[15:0]);

  always_comb begin
    reg_dst_p0    = 1'b0;
    alu_src_p0    = 1'b0;
    mem_to_reg_p0 = 1'b0;
    reg_write_p0  = 1'b0;
    mem_read_p0   = 1'b0;
    mem_write_p0  = 1'b0;
    branch_p0     = 1'b0;
    alu_op_p0     = 2'b00;
    unique case (opcode_p0)
      OP_RTYPE: begin
        reg_dst_p0   = 1'b1;
        reg_write_p0 = 1'b1;
        alu_op_p0    = 2'b10;
      end
      OP_LW: begin
        alu_src_p0    = 1'b1;
        mem_to_reg_p0 = 1'b1;
        reg_write_p0  = 1'b1;
        mem_read_p0   = 1'b1;
      end
      OP_SW: begin
        alu_src_p0   = 1'b1;
        mem_write_p0 = 1'b1;
      end
      OP_BEQ: begin
        branch_p0 = 1'b1;
        alu_op_p0 = 2'b01;
      end
      default: ;
    endcase
  end

  // Flush wins over the hazard: the ID instruction is wrong-path, so no stall is needed.
  assign hazard_p0 = ex_mem_read && (ex_rt != 5'd0) && ((ex_rt == rs_p0) || (ex_rt == rt_p0));
  assign stall     = hazard_p0 && !flush;
  assign bubble_p0 = flush || hazard_p0;

  // Stage p1: ID/EX register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_reg_dst    <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_op     <= 2'b00;
      ex_funct      <= 6'd0;
      ex_rs         <= 5'd0;
      ex_rt         <= 5'd0;
      ex_rd         <= 5'd0;
      ex_rd1        <= '0;
      ex_rd2        <= '0;
      ex_imm        <= '0;
      bubble_cnt    <= 16'd0;
    end else if (bubble_p0) begin
      ex_reg_dst    <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_op     <= 2'b00;
      ex_funct      <= 6'd0;
      ex_rs         <= 5'd0;
      ex_rt         <= 5'd0;
      ex_rd         <= 5'd0;
      ex_rd1        <= '0;
      ex_rd2        <= '0;
      ex_imm        <= '0;
      bubble_cnt    <= sat_inc16(bubble_cnt);
    end else begin
      ex_reg_dst    <= reg_dst_p0;
      ex_alu_src    <= alu_src_p0;
      ex_mem_to_reg <= mem_to_reg_p0;
      ex_reg_write  <= reg_write_p0;
      ex_mem_read   <= mem_read_p0;
      ex_mem_write  <= mem_write_p0;
      ex_branch     <= branch_p0;
      ex_alu_op     <= alu_op_p0;
      ex_funct      <= id_instr[5:0];
      ex_rs         <= rs_p0;
      ex_rt         <= rt_p0;
      ex_rd         <= id_instr[15:11];
      ex_rd1        <= id_rd1;
      ex_rd2        <= id_rd2;
      ex_imm        <= imm_p0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model pushes the expected EX contents
// when an instruction is driven, and they are popped and compared after the capturing edge.
module tb_id_ex_stage;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       id_instr = '0;
  logic [DATA_W-1:0] id_rd1 = '0;
  logic [DATA_W-1:0] id_rd2 = '0;
  logic              flush = 1'b0;
  logic              stall;
  logic              ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write;
  logic              ex_mem_read, ex_mem_write, ex_branch;
  logic [1:0]        ex_alu_op;
  logic [5:0]        ex_funct;
  logic [4:0]        ex_rs, ex_rt, ex_rd;
  logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm;
  logic [15:0]       bubble_cnt;

  id_ex_stage #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .flush(flush), .stall(stall),
    .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_alu_op(ex_alu_op), .ex_funct(ex_funct),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rd1, rd2, imm;
    logic [15:0] cnt;
  } ex_t;

  ex_t m_ex;
  ex_t sb_q[$];
  int  n_chk = 0;
  int  n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic model_hazard(input ex_t cur, input logic [31:0] instr);
    return cur.mem_read && (cur.rt != 5'd0) &&
           ((cur.rt == instr[25:21]) || (cur.rt == instr[20:16]));
  endfunction

  function automatic ex_t model_next(input ex_t cur, input logic [31:0] instr,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic fl);
    ex_t n;
    n = '0;
    if (fl || model_hazard(cur, instr)) begin
      n.cnt = (cur.cnt == 16'hFFFF) ? 16'hFFFF : cur.cnt + 16'd1;
    end else begin
      case (instr[31:26])
        6'd0:  begin n.reg_dst = 1; n.reg_write = 1; n.alu_op = 2'b10; end
        6'd35: begin n.alu_src = 1; n.mem_to_reg = 1; n.reg_write = 1; n.mem_read = 1; end
        6'd43: begin n.alu_src = 1; n.mem_write = 1; end
        6'd4:  begin n.branch = 1; n.alu_op = 2'b01; end
        default: ;
      endcase
      n.funct = instr[5:0];
      n.rs    = instr[25:21];
      n.rt    = instr[20:16];
      n.rd    = instr[15:11];
      n.rd1   = a;
      n.rd2   = b;
      n.imm   = {{16{instr[15]}}, instr[15:0]};
      n.cnt   = cur.cnt;
    end
    return n;
  endfunction

  task automatic compare_ex(input ex_t e);
    chk("reg_dst",    32'(ex_reg_dst),    32'(e.reg_dst));
    chk("alu_src",    32'(ex_alu_src),    32'(e.alu_src));
    chk("mem_to_reg", 32'(ex_mem_to_reg), 32'(e.mem_to_reg));
    chk("reg_write",  32'(ex_reg_write),  32'(e.reg_write));
    chk("mem_read",   32'(ex_mem_read),   32'(e.mem_read));
    chk("mem_write",  32'(ex_mem_write),  32'(e.mem_write));
    chk("branch",     32'(ex_branch),     32'(e.branch));
    chk("alu_op",     32'(ex_alu_op),     32'(e.alu_op));
    chk("funct",      32'(ex_funct),      32'(e.funct));
    chk("rs",         32'(ex_rs),         32'(e.rs));
    chk("rt",         32'(ex_rt),         32'(e.rt));
    chk("rd",         32'(ex_rd),         32'(e.rd));
    chk("rd1",        ex_rd1,             e.rd1);
    chk("rd2",        ex_rd2,             e.rd2);
    chk("imm",        ex_imm,             e.imm);
    chk("bubble_cnt", 32'(bubble_cnt),    32'(e.cnt));
  endtask

  // Drive one ID instruction, check combinational stall, push expectation, then pop after the edge.
  task automatic cycle(input logic [31:0] instr, input logic [31:0] a,
                       input logic [31:0] b, input logic fl);
    ex_t e;
    id_instr = instr;
    id_rd1   = a;
    id_rd2   = b;
    flush    = fl;
    #1;
    chk("stall", 32'(stall), 32'(model_hazard(m_ex, instr) && !fl));
    sb_q.push_back(model_next(m_ex, instr, a, b, fl));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      compare_ex(e);
      m_ex = e;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0]  ops [5];
    logic [31:0] ins;
    ops[0] = 6'd0; ops[1] = 6'd35; ops[2] = 6'd43; ops[3] = 6'd4; ops[4] = 6'd12;
    m_ex = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    compare_ex('0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // add $3,$1,$2
    cycle(32'h00221820, 32'd5, 32'd7, 1'b0);
    chk("add_funct", 32'(ex_funct), 32'd32);

    // lw $4,-4($1) then dependent add $5,$4,$2: one stall, one bubble, then add enters
    cycle(32'h8C24FFFC, 32'd1, 32'd2, 1'b0);
    chk("lw_imm", ex_imm, 32'hFFFFFFFC);
    cycle(32'h00822820, 32'd9, 32'd8, 1'b0);
    chk("lu_cnt", 32'(bubble_cnt), 32'd1);
    cycle(32'h00822820, 32'd9, 32'd8, 1'b0);
    chk("lu_rs", 32'(ex_rs), 32'd4);

    // lw $0 never causes a stall
    cycle(32'h8C200000, 32'd3, 32'd4, 1'b0);
    cycle(32'h00002820, 32'd0, 32'd0, 1'b0);
    chk("r0_cnt", 32'(bubble_cnt), 32'd1);

    // Flush with a simultaneous hazard: single bubble, no stall
    cycle(32'h8C24FFFC, 32'd1, 32'd2, 1'b0);
    cycle(32'h00822820, 32'd9, 32'd8, 1'b1);
    chk("fh_cnt", 32'(bubble_cnt), 32'd2);

    // Opcode 63 is a nop without counting; beq decode
    cycle(32'hFC221820, 32'd1, 32'd1, 1'b0);
    cycle(32'h10220003, 32'd6, 32'd6, 1'b0);
    chk("beq_imm", ex_imm, 32'd3);

    // Random mix of opcodes, registers, operands and flushes
    for (int i = 0; i < 60; i++) begin
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 4)];
      ins[25:21] = 5'($urandom_range(0, 5));
      ins[20:16] = 5'($urandom_range(0, 5));
      cycle(ins, $urandom, $urandom, ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset in the middle of a stall
    cycle(32'h8C24FFFC, 32'd1, 32'd2, 1'b0);
    id_instr = 32'h00822820;
    flush = 1'b0;
    #1;
    chk("pre_rst_stall", 32'(stall), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    compare_ex('0);
    chk("async_rst_stall", 32'(stall), 32'd0);
    m_ex = '0;
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Long flush run: counter saturates at 0xFFFF without wrapping
    flush = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", 32'(bubble_cnt), 32'h0000FFFE);
    @(posedge clk);
    #1;
    chk("sat_ffff", 32'(bubble_cnt), 32'h0000FFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_hold", 32'(bubble_cnt), 32'h0000FFFF);
    chk("sat_stall", 32'(stall), 32'd0);
    flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
